// File: rtl/bcd2bin.sv
// bcd2bin: converts four packed BCD digits (0000-9999) into a 14-bit binary
// value. It uses an iterative reverse double-dabble: 14 cycles of
// "shift right, then subtract 3 from every digit >= 8".
// Digits above 9 are rejected in one cycle, with err=1 and bin=0.
// The start/ready/done_tick handshake is the same as on bin2bcd.
module bcd2bin (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  bcd3,
   input  logic [3:0]  bcd2,
   input  logic [3:0]  bcd1,
   input  logic [3:0]  bcd0,
   output logic [13:0] bin,
   output logic        err,
   output logic        ready,
   output logic        done_tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] bcd_q, bcd_d;
   logic [13:0] bin_q, bin_d;
   logic [3:0]  n_q, n_d;
   logic        err_q, err_d;
   logic        bad_digit;

   // Undo the doubling carry: a digit that reads >= 8 after a right shift
   // picked up 10/2 = 5 from the digit above, so it must be reduced by 3.
   function automatic logic [15:0] fix_digits(input logic [15:0] v);
      logic [15:0] r;
      logic [3:0]  d;
      r = v;
      for (int i = 0; i < 4; i++) begin
         d = v[4*i +: 4];
         if (d >= 4'd8) begin
            d = d - 4'd3;
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   assign bad_digit = (bcd3 > 4'd9) || (bcd2 > 4'd9) ||
                      (bcd1 > 4'd9) || (bcd0 > 4'd9);

   // State and datapath registers; the reset returns everything to idle and clears it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         n_q     <= n_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept and validate a request, iterate, then report.
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      n_d     = n_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               err_d = 1'b0;
               bin_d = '0;
               if (bad_digit) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  bcd_d   = {bcd3, bcd2, bcd1, bcd0};
                  n_d     = 4'd14;
                  state_d = OP;
               end
            end
         end
         OP: begin
            // Shift {bcd, bin} right by one; the bcd LSB moves into the bin MSB.
            bin_d = {bcd_q[0], bin_q[13:1]};
            bcd_d = fix_digits({1'b0, bcd_q[15:1]});
            n_d   = n_q - 4'd1;
            if (n_q == 4'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bin       = bin_q;
   assign err       = err_q;
   assign ready     = (state_q == IDLE);
   assign done_tick = (state_q == DONE);

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed and random requests against an arithmetic model
// (value = 1000*d3 + 100*d2 + 10*d1 + d0; any digit > 9 is an error).
// The bench also covers latency, ignored start, held start and reset mid-conversion.
module tb_bcd2bin;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  bcd3, bcd2, bcd1, bcd0;
   logic [13:0] bin;
   logic        err;
   logic        ready;
   logic        done_tick;

   int n_checks = 0;
   int n_fail   = 0;

   bcd2bin dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bcd3      (bcd3),
      .bcd2      (bcd2),
      .bcd1      (bcd1),
      .bcd0      (bcd0),
      .bin       (bin),
      .err       (err),
      .ready     (ready),
      .done_tick (done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Issue one request. If poke_at is nonzero, a second request with other
   // digits is pulsed at that cycle; the DUT must ignore it.
   task automatic run_conv(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input int poke_at);
      int  exp_v;
      bit  exp_e;
      int  cnt;
      bit  seen;
      int  b;
      exp_e = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
      exp_v = exp_e ? 0 : (int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0));
      check_val("ready_before", int'(ready), 1);
      bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
      start = 1'b1;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) start = 1'b0;
         if (poke_at != 0 && cnt == poke_at) begin
            start = 1'b1;
            bcd3 = 4'd9; bcd2 = 4'd8; bcd1 = 4'd7; bcd0 = 4'd6;
         end
         if (poke_at != 0 && cnt == poke_at + 1) start = 1'b0;
         seen = done_tick;
      end
      check_val("latency", cnt, exp_e ? 1 : 15);
      check_val("bin", int'(bin), exp_v);
      check_val("err", int'(err), int'(exp_e));
      check_val("ready_in_done", int'(ready), 0);
      if (!exp_e) begin
         b = int'(bin);
         check_val("roundtrip_d3", (b / 1000) % 10, int'(d3));
         check_val("roundtrip_d2", (b / 100) % 10, int'(d2));
         check_val("roundtrip_d1", (b / 10) % 10, int'(d1));
         check_val("roundtrip_d0", b % 10, int'(d0));
      end
      @(negedge clk);
      check_val("ready_after", int'(ready), 1);
      check_val("done_tick_once", int'(done_tick), 0);
      check_val("bin_hold", int'(bin), exp_v);
   endtask

   initial begin
      int t[3];
      int k;
      int cnt;
      int ticks;
      logic [3:0] r3, r2, r1, r0;

      reset = 1'b0;
      start = 1'b0;
      bcd3 = '0; bcd2 = '0; bcd1 = '0; bcd0 = '0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", int'(ready), 1);
      check_val("rst_bin", int'(bin), 0);
      check_val("rst_err", int'(err), 0);
      check_val("rst_done_tick", int'(done_tick), 0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      run_conv(4'd9, 4'd9, 4'd9, 4'd9, 0);
      run_conv(4'd0, 4'd0, 4'd0, 4'd0, 0);
      run_conv(4'd1, 4'd2, 4'd3, 4'd4, 0);
      run_conv(4'd2, 4'd0, 4'd4, 4'd7, 0);
      run_conv(4'd0, 4'd0, 4'd1, 4'd0, 0);
      run_conv(4'd0, 4'd0, 4'd0, 4'd9, 0);
      run_conv(4'd0, 4'd0, 4'hC, 4'd0, 0);
      run_conv(4'd5, 4'd6, 4'd7, 4'd8, 0);
      run_conv(4'hF, 4'd1, 4'd1, 4'd1, 0);
      run_conv(4'd0, 4'd0, 4'd4, 4'd2, 5);

      // Random requests, mostly valid with an occasional illegal digit
      for (int i = 0; i < 30; i++) begin
         r3 = 4'($urandom_range(0, 9));
         r2 = 4'($urandom_range(0, 9));
         r1 = 4'($urandom_range(0, 9));
         r0 = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) r1 = 4'($urandom_range(10, 15));
         run_conv(r3, r2, r1, r0, 0);
      end

      // Start held high: one conversion every 16 cycles
      bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
      start = 1'b1;
      k = 0;
      cnt = 0;
      t[0] = 0; t[1] = 0; t[2] = 0;
      while (k < 3 && cnt < 80) begin
         @(negedge clk);
         cnt++;
         if (done_tick) begin
            t[k] = cnt;
            k++;
            check_val("held_bin", int'(bin), 1234);
         end
      end
      check_val("held_ticks", k, 3);
      check_val("held_period1", t[1] - t[0], 16);
      check_val("held_period2", t[2] - t[1], 16);
      start = 1'b0;
      cnt = 0;
      while (!ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check_val("held_back_to_idle", int'(ready), 1);

      // Reset during op aborts the conversion silently
      bcd3 = 4'd4; bcd2 = 4'd3; bcd1 = 4'd2; bcd0 = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check_val("midop_not_ready", int'(ready), 0);
      reset = 1'b0;
      @(negedge clk);
      check_val("abort_ready", int'(ready), 1);
      check_val("abort_bin", int'(bin), 0);
      check_val("abort_err", int'(err), 0);
      check_val("abort_done_tick", int'(done_tick), 0);
      reset = 1'b1;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_tick) ticks++;
      end
      check_val("abort_no_tick", ticks, 0);
      check_val("abort_idle", int'(ready), 1);

      // Reset wins over start at the same edge
      reset = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check_val("rst_vs_start_ready", int'(ready), 1);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check_val("rst_vs_start_idle", int'(ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter: the inverse of the existing `bin2bcd` block. It accepts four packed BCD digits (0000–9999) and returns the 14-bit binary value using an iterative reverse double-dabble: shift right, then subtract 3 from any digit ≥ 8. It uses the same start/ready/done_tick handshake as `bin2bcd`, so the two blocks can be chained for round-trip checks or fed from keypad/display logic on the board.

## Interface
- Parameters: none. Digit count (4) and result width (14) are fixed.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `start`  in  1  conversion request; sampled only in `idle`.
- `bcd3`  in  4  thousands digit.
- `bcd2`  in  4  hundreds digit.
- `bcd1`  in  4  tens digit.
- `bcd0`  in  4  units digit.
- `bin`  out  14  binary result, registered.
- `err`  out  1  last request held a digit > 9; registered.
- `ready`  out  1  high in `idle` only.
- `done_tick`  out  1  one-cycle pulse when `bin`/`err` become valid.

## Operation
- States: `idle`, `op`, `done`.
- **`idle`**
  - `ready`=1.
  - On `start`=1:
    - Clear `err`.
    - If any `bcdN` > 9: set `err`=1, `bin`=0, go to `done`.
    - Otherwise load `bcd_reg` = {bcd3,bcd2,bcd1,bcd0} (16 bits), clear `bin_reg` (14 bits), load iteration counter n=14, go to `op`.
  - `bcd` inputs are sampled only at this edge; later changes are ignored.
- **`op`** (one iteration per cycle):
  - Shift the 30-bit concatenation {`bcd_reg`, `bin_reg`} right by 1. The `bcd_reg` LSB enters the `bin_reg` MSB; 0 enters the `bcd_reg` MSB.
  - In the same cycle, for each of the 4 digits of the shifted `bcd_reg`: if digit ≥ 8, subtract 3 (4-bit, no borrow across digits).
  - Decrement n. When n reaches 0 after this iteration, go to `done`.
- **`done`**
  - `done_tick`=1, `ready`=0. Go to `idle` next cycle.
- `bin` is driven from `bin_reg`.
  - Valid from the `done` cycle until the next accepted `start`.
  - Holds intermediate shift values during `op`; consumers must qualify with `done_tick`/`ready`.
- `start` outside `idle` is ignored; no queuing.
- Counter is 4 bits; no wrap-around is possible (exits at 0).

## Timing
- Reset values: state=`idle`, `bin`=0, `err`=0, `ready`=1, `done_tick`=0, n=0, `bcd_reg`=0.
- Valid request (start accepted at edge k):
  - `op` occupies cycles k+1 … k+14.
  - `done_tick` high for exactly the cycle after edge k+14 (latency 15 cycles).
  - `ready` high again after edge k+15.
- Invalid-digit request: `done_tick` one cycle after the accepting edge (latency 1), with `err`=1 and `bin`=0.
- Back-to-back: `start` held high continuously gives one conversion every 16 cycles (idle, 14×op, done).
- Reset asserted in any state (including mid-`op`): at that edge return to reset values, and no `done_tick` is emitted for the aborted conversion.
- `reset` low and `start` high at the same edge: `reset` wins.

## Test plan
- After reset: `ready`=1, `bin`=0, `err`=0, `done_tick`=0. Then digits 9,9,9,9 with 1-cycle `start` → `done_tick` at +15 cycles, `bin`=0x270F, `err`=0.
- Digits 0,0,0,0 → `bin`=0; digits 1,2,3,4 → `bin`=0x04D2; digits 2,0,4,7 → `bin`=0x07FF. Feed each result into `bin2bcd` and check the digits round-trip.
- Digits 0,0,1,0 → `bin`=0x000A (exercises the −3 correction); digits 0,0,0,9 → `bin`=9.
- Digit `bcd1`=4'hC, others 0 → `done_tick` 1 cycle after start, `err`=1, `bin`=0. A following valid request clears `err`.
- `start` pulsed again at +5 cycles with different digits → ignored; result is for the first request. `start` held high → `done_tick` every 16 cycles.
- `reset` low at +7 cycles of `op` → next cycle `idle`, `bin`=0, `ready`=1, no `done_tick` within the next 20 cycles.
